// File: rtl/bp_resolve.sv
// bp_resolve: EX-stage branch resolution unit.
//
// Compares the predicted outcome of the two EX slots with the actual outcome.
// It is the producer side of the branch_predict update interface: it drives
// the registered update record and the table-init pulse.
// On a mispredict it requests an IF redirect and holds that request until IF
// accepts it. It also keeps saturating counters of resolved branches and of
// mispredicts.
//
// Ports
//   clk_i, rst_ni     clock, asynchronous active-low reset
//   bp_flush_req_i    re-initialise the predictor tables (1-cycle pulse)
//   tbl_rst_val_i     target value written into the tables on init
//   ex_valid_i        EX slot valid (slot0 is older)
//   ex_instr0_i/1_i   EX slot instruction + prediction
//   ex_taken_i        actual taken per slot
//   ex_target0_i/1_i  actual taken target per slot
//   redir_ack_i       IF accepted the redirect
//   ex_bp_init_o      table init pulse
//   tbl_rst_val_o     init value, valid with ex_bp_init_o
//   ex_bp_info_o      registered predictor update record
//   redir_valid_o     mispredict redirect request
//   redir_pc_o        correct next PC for the redirect
//   ex_kill_o         per-slot kill of younger work (combinational)
//   cnt_branch_o      resolved branch + jal count (saturating)
//   cnt_mispred_o     mispredict count (saturating)

package bp_resolve_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic        is_comp;
    logic        is_branch;
    logic        is_jal;
    logic        ptaken;
    logic [31:0] ptarget;
  } ir_reg_t;

  typedef struct packed {
    logic [1:0]  is_branch;
    logic [1:0]  is_jal;
    logic [1:0]  taken;
    logic [31:0] pc0;
    logic [31:0] pc1;
    logic [31:0] target0;
    logic [31:0] target1;
  } ex_bp_info_t;

endpackage

module bp_resolve
  import bp_resolve_pkg::*;
#(
  parameter int unsigned CntW        = 32,
  parameter bit          InitOnReset = 1'b1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            bp_flush_req_i,
  input  logic [31:0]     tbl_rst_val_i,
  input  logic [1:0]      ex_valid_i,
  input  ir_reg_t         ex_instr0_i,
  input  ir_reg_t         ex_instr1_i,
  input  logic [1:0]      ex_taken_i,
  input  logic [31:0]     ex_target0_i,
  input  logic [31:0]     ex_target1_i,
  input  logic            redir_ack_i,
  output logic            ex_bp_init_o,
  output logic [31:0]     tbl_rst_val_o,
  output ex_bp_info_t     ex_bp_info_o,
  output logic            redir_valid_o,
  output logic [31:0]     redir_pc_o,
  output logic [1:0]      ex_kill_o,
  output logic [CntW-1:0] cnt_branch_o,
  output logic [CntW-1:0] cnt_mispred_o
);

  typedef enum logic [1:0] {
    S_INIT  = 2'd0,
    S_RUN   = 2'd1,
    S_REDIR = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic        init_q;
  logic [31:0] tbl_rst_val_q;
  logic [31:0] redir_pc_q;
  ex_bp_info_t info_q;
  logic [CntW-1:0] cnt_branch_q, cnt_mispred_q;

  logic            resolve;
  logic            mis0, mis1, any_mis;
  logic [1:0]      live;
  logic [1:0]      upd_br, upd_jal, upd_any;
  logic [1:0]      br_inc;
  logic [31:0]     npc0, npc1, redir_pc_d;
  logic [CntW:0]   br_sum, mp_sum;
  logic [CntW-1:0] cnt_branch_d, cnt_mispred_d;

  // A jal is checked as a jal even if the decoder also flags it a branch.
  function automatic logic slot_mispred(input ir_reg_t ins, input logic taken,
                                        input logic [31:0] target);
    logic m;
    if (ins.is_jal)
      m = !ins.ptaken || (ins.ptarget != target);
    else if (ins.is_branch)
      m = (taken != ins.ptaken) || (taken && ins.ptaken && (ins.ptarget != target));
    else
      m = ins.ptaken;
    return m;
  endfunction

  function automatic logic [31:0] correct_pc(input ir_reg_t ins, input logic taken,
                                             input logic [31:0] target);
    logic [31:0] p;
    if (taken)
      p = target;
    else
      p = ins.pc + (ins.is_comp ? 32'd2 : 32'd4);
    return p;
  endfunction

  // Resolution, kill and next-state logic. A flush pre-empts everything,
  // including resolution in the same cycle.
  always_comb begin
    state_d    = state_q;
    resolve    = (state_q == S_RUN) && !bp_flush_req_i;

    mis0       = resolve && ex_valid_i[0] && slot_mispred(ex_instr0_i, ex_taken_i[0], ex_target0_i);
    mis1       = resolve && ex_valid_i[1] && !mis0 &&
                 slot_mispred(ex_instr1_i, ex_taken_i[1], ex_target1_i);
    any_mis    = mis0 || mis1;

    ex_kill_o  = mis0 ? 2'b11 : (mis1 ? 2'b10 : 2'b00);

    // Slot1 is dropped only when the older slot0 mispredicted.
    live       = {ex_valid_i[1] && !mis0, ex_valid_i[0]} & {2{resolve}};
    upd_br     = live & {ex_instr1_i.is_branch, ex_instr0_i.is_branch};
    upd_jal    = live & {ex_instr1_i.is_jal, ex_instr0_i.is_jal};
    upd_any    = upd_br | upd_jal;
    br_inc     = {1'b0, upd_any[0]} + {1'b0, upd_any[1]};

    npc0       = correct_pc(ex_instr0_i, ex_taken_i[0], ex_target0_i);
    npc1       = correct_pc(ex_instr1_i, ex_taken_i[1], ex_target1_i);
    redir_pc_d = mis0 ? npc0 : npc1;

    br_sum        = {1'b0, cnt_branch_q} + {{(CntW-1){1'b0}}, br_inc};
    mp_sum        = {1'b0, cnt_mispred_q} + {{CntW{1'b0}}, any_mis};
    cnt_branch_d  = br_sum[CntW] ? {CntW{1'b1}} : br_sum[CntW-1:0];
    cnt_mispred_d = mp_sum[CntW] ? {CntW{1'b1}} : mp_sum[CntW-1:0];

    unique case (state_q)
      S_INIT:  state_d = S_RUN;
      S_RUN:   if (any_mis) state_d = S_REDIR;
      S_REDIR: if (redir_ack_i) state_d = S_RUN;
      default: state_d = S_RUN;
    endcase

    if (bp_flush_req_i) state_d = S_INIT;
  end

  // State, init pulse, redirect PC, update record and counters.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      if (InitOnReset) state_q <= S_INIT;
      else             state_q <= S_RUN;
      init_q        <= 1'b0;
      tbl_rst_val_q <= '0;
      redir_pc_q    <= '0;
      info_q        <= '0;
      cnt_branch_q  <= '0;
      cnt_mispred_q <= '0;
    end else begin
      state_q <= state_d;

      // A flush arriving while already in S_INIT defers the pulse, so each
      // init sequence produces exactly one pulse.
      init_q <= (state_q == S_INIT) && !bp_flush_req_i;
      if (state_q == S_INIT) tbl_rst_val_q <= tbl_rst_val_i;

      if (any_mis) redir_pc_q <= redir_pc_d;

      if (resolve) begin
        info_q.is_branch <= upd_br;
        info_q.is_jal    <= upd_jal;
        info_q.taken     <= ex_taken_i;
        info_q.pc0       <= ex_instr0_i.pc;
        info_q.pc1       <= ex_instr1_i.pc;
        info_q.target0   <= ex_target0_i;
        info_q.target1   <= ex_target1_i;
        cnt_branch_q     <= cnt_branch_d;
        cnt_mispred_q    <= cnt_mispred_d;
      end else begin
        info_q.is_branch <= 2'b00;
        info_q.is_jal    <= 2'b00;
      end
    end
  end

  assign ex_bp_init_o  = init_q;
  assign tbl_rst_val_o = tbl_rst_val_q;
  assign ex_bp_info_o  = info_q;
  assign redir_valid_o = (state_q == S_REDIR);
  assign redir_pc_o    = redir_pc_q;
  assign cnt_branch_o  = cnt_branch_q;
  assign cnt_mispred_o = cnt_mispred_q;

endmodule
